// File: rtl/dma_cache_pkg.sv
// Shared constants and state encoding for the CoreDMA cache fill/read engines.
package dma_cache_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

endpackage

// File: rtl/dma_cache_skid_fifo.sv
// Small synchronous FIFO carrying a data word plus a last-beat flag.
module dma_cache_skid_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_push,
    input  logic [DATA_WIDTH-1:0]        i_push_data,
    input  logic                         i_push_last,
    input  logic                         i_pop,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_last,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic [DEPTH-1:0]      r_last_mem;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_do_pop;
    logic                  w_do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last_mem <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_data_mem[r_wr_ptr] <= i_push_data;
                r_last_mem[r_wr_ptr] <= i_push_last;
                r_wr_ptr             <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_data_mem[r_rd_ptr];
    assign o_last  = o_valid && r_last_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/dma_cache_reader.sv
// Cache read engine: turns an (address, length) command into sequential SRAM reads
// and presents the returned words as a valid/ready stream with a last flag.
module dma_cache_reader
    import dma_cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = dma_cache_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = dma_cache_pkg::ADDR_WIDTH,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [ADDR_WIDTH:0]     i_cmd_len,
    output logic [ADDR_WIDTH-1:0]   o_r_addr,
    output logic                    o_r_en,
    output logic                    o_r_data_en,
    output logic                    o_r_data_srst_n,
    input  logic [DATA_WIDTH-1:0]   i_r_data,
    output logic [DATA_WIDTH-1:0]   o_out_data,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic                    o_out_last,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int unsigned LEN_W = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned INF_W = $clog2(RD_LATENCY + 1);

    state_e                  r_state;
    state_e                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LEN_W-1:0]        r_remaining;
    logic [RD_LATENCY-1:0]   r_pipe_vld;
    logic [RD_LATENCY-1:0]   r_pipe_last;
    logic                    r_done;
    logic                    w_done_next;
    logic                    w_issue;
    logic                    w_issue_last;
    logic                    w_accept;
    logic [INF_W-1:0]        w_inflight;
    logic [CNT_W-1:0]        w_fifo_count;
    logic                    w_pop;
    logic                    w_last_hs;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + INF_W'(r_pipe_vld[i]);
        end
    end

    // Reads in flight plus buffered words never exceed the buffer, so a stalled
    // consumer can never cause returning SRAM data to be dropped.
    assign w_issue      = (r_state == ISSUE) && (r_remaining != '0) &&
                          ((32'(w_inflight) + 32'(w_fifo_count)) < FIFO_DEPTH);
    assign w_issue_last = w_issue && (r_remaining == LEN_W'(1));
    assign w_accept     = (r_state == IDLE) && i_cmd_valid;
    assign w_pop        = o_out_valid && i_out_ready;
    assign w_last_hs    = w_pop && o_out_last;

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_len != '0) begin
                        w_state_next = ISSUE;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (w_issue_last) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Stay one extra cycle so DONE is seen while BUSY is still high.
                if (r_done) begin
                    w_state_next = IDLE;
                end else if (w_last_hs) begin
                    w_done_next = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            if (w_accept) begin
                r_addr      <= i_cmd_addr;
                r_remaining <= i_cmd_len;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end
            r_pipe_vld[0]  <= w_issue;
            r_pipe_last[0] <= w_issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
        end
    end

    dma_cache_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (r_pipe_vld[RD_LATENCY-1]),
        .i_push_data (i_r_data),
        .i_push_last (r_pipe_last[RD_LATENCY-1]),
        .i_pop       (w_pop),
        .o_valid     (o_out_valid),
        .o_data      (o_out_data),
        .o_last      (o_out_last),
        .o_count     (w_fifo_count)
    );

    assign o_cmd_ready     = (r_state == IDLE);
    assign o_busy          = (r_state != IDLE);
    assign o_done          = r_done;
    assign o_r_en          = w_issue;
    assign o_r_addr        = r_addr;
    assign o_r_data_en     = 1'b1;
    assign o_r_data_srst_n = ~i_reset;

endmodule

// File: tb/tb_dma_cache_reader.sv
// Bench for dma_cache_reader: 2-cycle SRAM model, scoreboard of expected beats and addresses.
module tb_dma_cache_reader;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_addr;
    logic [8:0]  cmd_len;
    logic [7:0]  r_addr;
    logic        r_en;
    logic        r_data_en;
    logic        r_data_srst_n;
    logic [63:0] r_data;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    dma_cache_reader u_dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_cmd_valid     (cmd_valid),
        .o_cmd_ready     (cmd_ready),
        .i_cmd_addr      (cmd_addr),
        .i_cmd_len       (cmd_len),
        .o_r_addr        (r_addr),
        .o_r_en          (r_en),
        .o_r_data_en     (r_data_en),
        .o_r_data_srst_n (r_data_srst_n),
        .i_r_data        (r_data),
        .o_out_data      (out_data),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_out_last      (out_last),
        .o_busy          (busy),
        .o_done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Cache model: read address registered, then output register.
    logic [63:0] mem [256];
    logic [63:0] c_stage1;
    logic [63:0] c_stage2;
    always @(posedge clk) begin
        if (r_en) c_stage1 <= mem[r_addr];
        if (!r_data_srst_n) c_stage2 <= '0;
        else                c_stage2 <= c_stage1;
    end
    assign r_data = c_stage2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ready_mode = 0;
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(99) < 30);
            default: out_ready = 1'b0;
        endcase
    end

    logic [7:0]  exp_addr_q [$];
    logic [63:0] exp_data_q [$];
    bit          exp_last_q [$];

    int acc_lbl, first_ren, first_vld, last_lbl, done_lbl;
    int ren_cnt, hs_cnt, outstanding;
    int done_cnt = 0;
    bit          have_prev;
    logic        prev_valid, prev_ready, prev_last;
    logic [63:0] prev_data;

    always @(negedge clk) begin
        if (reset) begin
            exp_addr_q.delete();
            exp_data_q.delete();
            exp_last_q.delete();
            outstanding = 0;
            have_prev   = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                acc_lbl   = cyc + 1;
                first_ren = -1;
                first_vld = -1;
                last_lbl  = -1;
                done_lbl  = -1;
                ren_cnt   = 0;
                hs_cnt    = 0;
            end
            if (r_en) begin
                ren_cnt++;
                if (first_ren < 0) first_ren = cyc + 1;
                if (exp_addr_q.size() == 0) check("r_en_extra", 64'(exp_addr_q.size()), 64'd1);
                else check("r_addr", 64'(r_addr), 64'(exp_addr_q.pop_front()));
                check("credit", 64'(outstanding < 4), 64'd1);
            end
            if (have_prev && prev_valid && !prev_ready) begin
                check("stable_valid", 64'(out_valid), 64'd1);
                check("stable_data", out_data, prev_data);
                check("stable_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && first_vld < 0) first_vld = cyc + 1;
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_data_q.size() == 0) begin
                    check("beat_extra", 64'(exp_data_q.size()), 64'd1);
                end else begin
                    check("out_data", out_data, exp_data_q.pop_front());
                    check("out_last", 64'(out_last), 64'(exp_last_q.pop_front()));
                end
                if (out_last) last_lbl = cyc + 1;
            end
            if (done) begin
                done_cnt++;
                done_lbl = cyc + 1;
            end
            outstanding += int'(r_en) - int'(out_valid && out_ready);
            have_prev  = 1'b1;
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic start_cmd(input logic [7:0] a, input int len);
        bit got = 1'b0;
        for (int i = 0; i < len; i++) begin
            logic [7:0] wa = a + 8'(i);
            exp_addr_q.push_back(wa);
            exp_data_q.push_back(mem[wa]);
            exp_last_q.push_back(i == len - 1);
        end
        @(posedge clk); #1;
        cmd_addr  = a;
        cmd_len   = 9'(len);
        cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("cmd_accept", 64'(got), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int len, input int budget, input bit timing);
        int start = done_cnt;
        bit got   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cnt != start) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(got), 64'd1);
        if (got) begin
            check("busy_in_done", 64'(busy), 64'(len != 0));
            check("ready_in_done", 64'(cmd_ready), 64'(len == 0));
            @(negedge clk); #1;
            check("busy_after", 64'(busy), 64'd0);
            check("ready_after", 64'(cmd_ready), 64'd1);
            check("done_pulse", 64'(done), 64'd0);
        end
        check("r_en_count", 64'(ren_cnt), 64'(len));
        check("beats_left", 64'(exp_data_q.size()), 64'd0);
        if (timing) begin
            if (len == 0) begin
                check("len0_no_valid", 64'(first_vld), 64'(-1));
                check("len0_done_at", 64'(done_lbl), 64'(acc_lbl + 1));
            end else begin
                check("first_r_en_at", 64'(first_ren), 64'(acc_lbl + 1));
                check("first_valid_at", 64'(first_vld), 64'(acc_lbl + 4));
                check("last_beat_at", 64'(last_lbl), 64'(acc_lbl + 3 + len));
                check("done_at", 64'(done_lbl), 64'(acc_lbl + 4 + len));
            end
        end
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (hs_cnt >= n) break;
        end
        check("reach_beat", 64'(hs_cnt >= n), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_r_en", 64'(r_en), 64'd0);
        check("rst_r_addr", 64'(r_addr), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_srst_n", 64'(r_data_srst_n), 64'd0);
        check("r_data_en", 64'(r_data_en), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("srst_n_run", 64'(r_data_srst_n), 64'd1);

        // Basic command with full timing.
        start_cmd(8'h10, 4);
        wait_done(4, 100, 1'b1);

        // Address wrap.
        start_cmd(8'hFE, 4);
        wait_done(4, 100, 1'b1);

        // Zero-length command.
        start_cmd(8'h33, 0);
        wait_done(0, 20, 1'b1);

        // Full cache with a bursty consumer.
        ready_mode = 1;
        start_cmd(8'h00, 256);
        wait_done(256, 5000, 1'b0);
        ready_mode = 0;

        // Long consumer stall mid-command.
        start_cmd(8'h20, 16);
        wait_beats(3);
        ready_mode = 2;
        repeat (10) @(negedge clk);
        #1;
        check("stall_r_en", 64'(r_en), 64'd0);
        check("stall_valid", 64'(out_valid), 64'd1);
        ready_mode = 0;
        wait_done(16, 200, 1'b0);

        // Reset in the middle of a command.
        start_cmd(8'h40, 8);
        wait_beats(3);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_r_en", 64'(r_en), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_ready", 64'(cmd_ready), 64'd1);
        dc = done_cnt;
        repeat (10) @(negedge clk);
        #1;
        check("no_done_after_rst", 64'(done_cnt), 64'(dc));

        start_cmd(8'h80, 5);
        wait_done(5, 100, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
